sync_generator: RTL

Produces a raster timing stream of `hsync`, `vsync` and data-enable, plus the matching pixel coordinates and a frame counter, from programmable horizontal and vertical timing parameters. It is the transmit-side counterpart of the location-tracking logic that recovers (x, y, frame) from sync pulses. It drives test patterns and replayed frames into the detection pipeline, and it is the timing master for the frame source. A run/stop control starts output only at a frame boundary and stops it only at a frame boundary, so downstream blocks never see a partial frame.

---
 rtl/sync_generator.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/sync_generator.sv
// Raster timing master: hsync/vsync/de/sof plus (x, y, frame) from programmable timing.
// Run/stop requests are honoured only at frame boundaries, so no partial frame is emitted.
module sync_generator #(
    parameter int unsigned LOC_SIZE = 12,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                en_i,
    input  logic                run_i,
    output logic                hsync_o,
    output logic                vsync_o,
    output logic                de_o,
    output logic                sof_o,
    output logic [LOC_SIZE-1:0] x_o,
    output logic [LOC_SIZE-1:0] y_o,
    output logic [LOC_SIZE-1:0] frame_o,
    output logic                busy_o
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // All thresholds are below the totals, so they fit in LOC_SIZE bits.
    localparam logic [LOC_SIZE-1:0] HLast      = LOC_SIZE'(H_TOTAL - 1);
    localparam logic [LOC_SIZE-1:0] VLast      = LOC_SIZE'(V_TOTAL - 1);
    localparam logic [LOC_SIZE-1:0] HActEnd    = LOC_SIZE'(H_ACTIVE);
    localparam logic [LOC_SIZE-1:0] VActEnd    = LOC_SIZE'(V_ACTIVE);
    localparam logic [LOC_SIZE-1:0] HSyncStart = LOC_SIZE'(H_ACTIVE + H_FP);
    localparam logic [LOC_SIZE-1:0] HSyncEnd   = LOC_SIZE'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [LOC_SIZE-1:0] VSyncStart = LOC_SIZE'(V_ACTIVE + V_FP);
    localparam logic [LOC_SIZE-1:0] VSyncEnd   = LOC_SIZE'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [LOC_SIZE-1:0] One        = LOC_SIZE'(1);
    localparam logic [LOC_SIZE-1:0] Zero       = '0;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain
    } state_e;

    state_e              state_q, state_d;
    logic [LOC_SIZE-1:0] h_q, h_d;
    logic [LOC_SIZE-1:0] v_q, v_d;
    logic [LOC_SIZE-1:0] frame_q, frame_d;
    logic                hsync_q, hsync_d;
    logic                vsync_q, vsync_d;
    logic                de_q, de_d;
    logic                sof_q, sof_d;
    logic                active_d;

    logic                h_last;
    logic                v_last;
    logic                frame_end;
    logic [LOC_SIZE-1:0] h_inc;
    logic [LOC_SIZE-1:0] v_inc;

    always_comb begin
        h_last    = (h_q == HLast);
        v_last    = (v_q == VLast);
        frame_end = h_last && v_last;
        h_inc     = h_last ? Zero : h_q + One;
        if (h_last) begin
            v_inc = v_last ? Zero : v_q + One;
        end else begin
            v_inc = v_q;
        end
    end

    // Next state and next position; the stream only ever stops on the frame-end edge.
    always_comb begin
        state_d  = state_q;
        h_d      = h_q;
        v_d      = v_q;
        frame_d  = frame_q;
        active_d = 1'b1;
        unique case (state_q)
            StIdle: begin
                h_d = Zero;
                v_d = Zero;
                if (run_i) begin
                    state_d = StRun;
                end else begin
                    active_d = 1'b0;
                end
            end
            StRun: begin
                h_d = h_inc;
                v_d = v_inc;
                if (frame_end) begin
                    frame_d = frame_q + One;
                end else if (!run_i) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                h_d = h_inc;
                v_d = v_inc;
                if (frame_end) begin
                    frame_d  = frame_q + One;
                    state_d  = StIdle;
                    active_d = 1'b0;
                end else if (run_i) begin
                    state_d = StRun;
                end
            end
            default: begin
                state_d  = StIdle;
                h_d      = Zero;
                v_d      = Zero;
                active_d = 1'b0;
            end
        endcase
    end

    // Decode the upcoming position so outputs are valid during the position they describe.
    always_comb begin
        de_d    = active_d && (h_d < HActEnd) && (v_d < VActEnd);
        hsync_d = active_d && (h_d >= HSyncStart) && (h_d < HSyncEnd);
        vsync_d = active_d && (v_d >= VSyncStart) && (v_d < VSyncEnd);
        sof_d   = active_d && (h_d == Zero) && (v_d == Zero);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= StIdle;
            h_q     <= '0;
            v_q     <= '0;
            frame_q <= '0;
            hsync_q <= 1'b0;
            vsync_q <= 1'b0;
            de_q    <= 1'b0;
            sof_q   <= 1'b0;
        end else if (en_i) begin
            state_q <= state_d;
            h_q     <= h_d;
            v_q     <= v_d;
            frame_q <= frame_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            de_q    <= de_d;
            sof_q   <= sof_d;
        end
    end

    assign hsync_o = hsync_q;
    assign vsync_o = vsync_q;
    assign de_o    = de_q;
    assign sof_o   = sof_q;
    assign x_o     = h_q;
    assign y_o     = v_q;
    assign frame_o = frame_q;
    assign busy_o  = (state_q != StIdle);

endmodule
